// File: rtl/lc3b_mem_unit.sv
// LC-3b memory access unit: sequenced word/byte load/store with lane enables and byte-load extension.
// Optional ACCESS-phase timeout abort is compiled in when MEM_UNIT_TIMEOUT_EN is defined.
module lc3b_mem_unit #(
  parameter int WIDTH          = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic                  byte_access,
  input  logic                  sext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WIDTH/8-1:0]    mem_byte_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_resp
);
  localparam int NB = WIDTH / 8;
  localparam int LB = $clog2(NB);

  if ((WIDTH != 16 && WIDTH != 32) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("lc3b_mem_unit: WIDTH must be 16 or 32 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state, state_next;
  logic           we_q, byte_q, sext_q;
  logic [LB-1:0]  lane_q;
  logic [NB-1:0]  be_q;
  logic           resp_ok;

  function automatic logic [7:0] pick_lane(input logic [WIDTH-1:0] d, input logic [LB-1:0] l);
    return d[{l, 3'b000} +: 8];
  endfunction

  function automatic logic [WIDTH-1:0] extend_byte(input logic [7:0] b, input logic s);
    return {{(WIDTH-8){s & b[7]}}, b};
  endfunction

`ifdef MEM_UNIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
  logic          timeout;
  logic          err_q;

  // A response on the last counted edge takes priority over the abort.
  assign timeout = (state == ACCESS) && !mem_resp && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != ACCESS) timer <= '0;
      else                 timer <= timer + TW'(1);
      if (state == ACCESS) err_q <= timeout;
    end
  end

  assign err = (state == DONE) && err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    resp_ok         = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    case (state)
      IDLE: begin
        if (req) state_next = ACCESS;
      end
      ACCESS: begin
        busy            = 1'b1;
        mem_read        = !we_q;
        mem_write       = we_q;
        mem_byte_enable = be_q;
        if (mem_resp) begin
          resp_ok    = 1'b1;
          state_next = DONE;
        end
`ifdef MEM_UNIT_TIMEOUT_EN
        if (timeout) state_next = DONE;
`endif
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch (IDLE) and load capture (ACCESS response edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      lane_q      <= '0;
      be_q        <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
    end else begin
      if (state == IDLE && req) begin
        we_q   <= we;
        byte_q <= byte_access;
        sext_q <= sext;
        lane_q <= addr[LB-1:0];
        if (byte_access) begin
          mem_address <= addr;
          mem_wdata   <= {NB{wdata[7:0]}};
          be_q        <= we ? (NB'(1) << addr[LB-1:0]) : '1;
        end else begin
          mem_address <= {addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
          mem_wdata   <= wdata;
          be_q        <= '1;
        end
      end
      if (resp_ok && !we_q)
        rdata <= byte_q ? extend_byte(pick_lane(mem_rdata, lane_q), sext_q) : mem_rdata;
    end
  end

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Scoreboard bench for lc3b_mem_unit: 16-bit and 32-bit instances, expected results queued at issue.
module tb_lc3b_mem_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req16 = 0, we16 = 0, byte16 = 0, sext16 = 0;
  logic [15:0] addr16 = '0, wdata16 = '0, mrdata16 = '0;
  logic [15:0] rdata16, maddr16, mwdata16;
  logic [1:0]  be16;
  logic        busy16, done16, err16, mrd16, mwr16;
  logic        mresp16 = 0;

  logic        req32 = 0, we32 = 0, byte32 = 0, sext32 = 0;
  logic [15:0] addr32 = '0, maddr32;
  logic [31:0] wdata32 = '0, mrdata32 = '0, rdata32, mwdata32;
  logic [3:0]  be32;
  logic        busy32, done32, err32, mrd32, mwr32;
  logic        mresp32 = 0;

  lc3b_mem_unit #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .we(we16), .byte_access(byte16), .sext(sext16),
    .addr(addr16), .wdata(wdata16), .rdata(rdata16), .busy(busy16), .done(done16), .err(err16),
    .mem_read(mrd16), .mem_write(mwr16), .mem_byte_enable(be16), .mem_address(maddr16),
    .mem_wdata(mwdata16), .mem_rdata(mrdata16), .mem_resp(mresp16));

  lc3b_mem_unit #(.WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(255)) dut32 (
    .clk(clk), .rst_n(rst_n), .req(req32), .we(we32), .byte_access(byte32), .sext(sext32),
    .addr(addr32), .wdata(wdata32), .rdata(rdata32), .busy(busy32), .done(done32), .err(err32),
    .mem_read(mrd32), .mem_write(mwr32), .mem_byte_enable(be32), .mem_address(maddr32),
    .mem_wdata(mwdata32), .mem_rdata(mrdata32), .mem_resp(mresp32));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;

  // Memory models: dut16 answers after resp_wait16 strobe cycles (negative = never); dut32 answers at once.
  int resp_wait16 = 0;
  int wcnt16 = 0;
  always @(negedge clk) begin
    if (mrd16 || mwr16) begin
      mresp16 = (resp_wait16 >= 0) && (wcnt16 >= resp_wait16);
      wcnt16++;
    end else begin
      mresp16 = 1'b0;
      wcnt16 = 0;
    end
    mresp32 = mrd32 || mwr32;
  end

  always @(negedge clk) begin
    if (done16) begin
      chk("sb16_nonempty", 64'(q16.size() != 0), 64'd1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        chk("rdata16", 64'(rdata16), 64'(e16.rd));
        chk("err16", 64'(err16), 64'(e16.err));
      end
    end
    if (done32) begin
      chk("sb32_nonempty", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e32 = q32.pop_front();
        chk("rdata32", 64'(rdata32), 64'(e32.rd));
        chk("err32", 64'(err32), 64'(e32.err));
      end
    end
  end

  task automatic acc16(input logic w, input logic b, input logic s, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] rd, input int wt,
                       input logic [15:0] exp_rd, input logic [15:0] exp_addr,
                       input logic [15:0] exp_wd, input logic [1:0] exp_be,
                       input logic exp_err, input int exp_lat);
    int n;
    q16.push_back('{{16'h0, exp_rd}, exp_err});
    resp_wait16 = wt;
    mrdata16 = rd;
    @(negedge clk);
    req16 = 1; we16 = w; byte16 = b; sext16 = s; addr16 = a; wdata16 = wd;
    @(negedge clk);
    req16 = 0; we16 = ~w; addr16 = ~a; wdata16 = ~wd;
    chk("busy16", 64'(busy16), 64'd1);
    chk("strobes16", 64'({mrd16, mwr16}), 64'({~w, w}));
    chk("maddr16", 64'(maddr16), 64'(exp_addr));
    chk("be16", 64'(be16), 64'(exp_be));
    if (w) chk("mwdata16", 64'(mwdata16), 64'(exp_wd));
    n = 1;
    while (!done16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency16", 64'(n), 64'(exp_lat));
    chk("done_strobes16", 64'({mrd16, mwr16}), 64'd0);
    chk("done_be16", 64'(be16), 64'd0);
  endtask

  task automatic acc32(input logic w, input logic b, input logic s, input logic [15:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] exp_rd,
                       input logic [15:0] exp_addr, input logic [31:0] exp_wd, input logic [3:0] exp_be);
    int n;
    q32.push_back('{exp_rd, 1'b0});
    mrdata32 = rd;
    @(negedge clk);
    req32 = 1; we32 = w; byte32 = b; sext32 = s; addr32 = a; wdata32 = wd;
    @(negedge clk);
    req32 = 0; we32 = ~w; addr32 = ~a; wdata32 = ~wd;
    chk("strobes32", 64'({mrd32, mwr32}), 64'({~w, w}));
    chk("maddr32", 64'(maddr32), 64'(exp_addr));
    chk("be32", 64'(be32), 64'(exp_be));
    if (w) chk("mwdata32", 64'(mwdata32), 64'(exp_wd));
    n = 1;
    while (!done32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency32", 64'(n), 64'd2);
  endtask

  initial begin
    int dcnt;
    repeat (2) @(negedge clk);
    chk("rst_rdata", 64'(rdata16), 64'd0);
    chk("rst_ctrl", 64'({busy16, done16, err16, mrd16, mwr16}), 64'd0);
    chk("rst_be", 64'(be16), 64'd0);
    chk("rst_maddr", 64'(maddr16), 64'd0);
    rst_n = 1;

    // Reset asserted mid-access: strobes drop immediately and no done follows
    resp_wait16 = -1;
    @(negedge clk);
    req16 = 1; we16 = 0; byte16 = 0; addr16 = 16'h1234;
    @(negedge clk);
    req16 = 0;
    chk("pre_rst_read", 64'(mrd16), 64'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ctrl", 64'({busy16, done16, mrd16, mwr16}), 64'd0);
    chk("async_rst_maddr", 64'(maddr16), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ctrl", 64'({busy16, done16, err16, mrd16}), 64'd0);

    // Word load with 3 wait cycles, then byte loads
    acc16(0, 0, 0, 16'h3001, 16'h0, 16'hBEEF, 3, 16'hBEEF, 16'h3000, 16'h0, 2'b11, 0, 5);
    acc16(0, 1, 1, 16'h3001, 16'h0, 16'h80AA, 0, 16'hFF80, 16'h3001, 16'h0, 2'b11, 0, 2);
    acc16(0, 1, 0, 16'h3000, 16'h0, 16'h80AA, 1, 16'h00AA, 16'h3000, 16'h0, 2'b11, 0, 3);
    acc16(0, 1, 1, 16'h3000, 16'h0, 16'h7F7F, 0, 16'h007F, 16'h3000, 16'h0, 2'b11, 0, 2);
    // Stores leave rdata alone
    acc16(1, 0, 0, 16'h3003, 16'h1234, 16'hFFFF, 2, 16'h007F, 16'h3002, 16'h1234, 2'b11, 0, 4);
    acc16(1, 1, 0, 16'h0005, 16'h007E, 16'hFFFF, 0, 16'h007F, 16'h0005, 16'h7E7E, 2'b10, 0, 2);

    // Back-to-back with req held high and immediate response
    resp_wait16 = 0;
    mrdata16 = 16'h5A5A;
    repeat (3) q16.push_back('{32'h0000_5A5A, 1'b0});
    @(negedge clk);
    req16 = 1; we16 = 0; byte16 = 0; addr16 = 16'h0100;
    dcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done16) begin
        dcnt++;
        chk("b2b_phase", 64'(i % 3), 64'd2);
      end
      if (i == 4) chk("b2b_busy", 64'(busy16), 64'd1);
    end
    req16 = 0;
    chk("b2b_count", 64'(dcnt), 64'd3);

`ifdef MEM_UNIT_TIMEOUT_EN
    acc16(0, 0, 0, 16'h4000, 16'h0, 16'hDEAD, -1, 16'h5A5A, 16'h4000, 16'h0, 2'b11, 1, 5);
`endif
    // Response on the 4th ACCESS edge completes normally
    acc16(0, 0, 0, 16'h2000, 16'h0, 16'h1111, 3, 16'h1111, 16'h2000, 16'h0, 2'b11, 0, 5);

    // 32-bit bus: word load, sign-extended byte load from lane 3, byte store to lane 2
    acc32(0, 0, 0, 16'h0006, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 16'h0004, 32'h0, 4'b1111);
    acc32(0, 1, 1, 16'h0007, 32'h0, 32'h8123_4567, 32'hFFFF_FF81, 16'h0007, 32'h0, 4'b1111);
    acc32(1, 1, 0, 16'h0006, 32'h0000_005C, 32'h0, 32'hFFFF_FF81, 16'h0006, 32'h5C5C_5C5C, 4'b0100);

    repeat (3) @(negedge clk);
    chk("sb16_drained", 64'(q16.size()), 64'd0);
    chk("sb32_drained", 64'(q32.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
